// File: rtl/ring_router_demux_if.sv
// ============================================================================
//  Module      : dii_channel
//  Description : DII flit channel (16-bit data, first/last framing, valid/ready).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dii_channel;
  logic [15:0] data;
  logic        first;
  logic        last;
  logic        valid;
  logic        ready;

  modport master (output data, output first, output last, output valid, input  ready);
  modport slave  (input  data, input  first, input  last, input  valid, output ready);
endinterface

`default_nettype wire

// File: rtl/ring_router_demux.sv
// ============================================================================
//  Module      : ring_router_demux
//  Description : Debug-ring ingress; steers each worm to the local port or on
//                down the ring, discarding and counting orphan flits.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ring_router_demux #(
  parameter int DEST_WIDTH = 10,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DEST_WIDTH-1:0] id,
  dii_channel.slave             in,
  dii_channel.master            out_local,
  dii_channel.master            out_ring,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WORM_LOCAL = 2'd1,
    WORM_RING  = 2'd2
  } state_t;

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_drop_cnt;

  logic w_dest_hit;
  logic w_sel_local;
  logic w_sel_ring;
  logic w_xfer;
  logic w_orphan;

  assign w_dest_hit = (in.data[DEST_WIDTH-1:0] == id);

  // In IDLE the decision comes from the head flit; mid-worm it is locked by state.
  assign w_sel_local = (r_state == WORM_LOCAL) || ((r_state == IDLE) && in.first &&  w_dest_hit);
  assign w_sel_ring  = (r_state == WORM_RING)  || ((r_state == IDLE) && in.first && !w_dest_hit);

  // Ready never looks at in.valid; orphans in IDLE are always accepted.
  assign in.ready = !rst && (w_sel_local ? out_local.ready :
                             w_sel_ring  ? out_ring.ready  : 1'b1);

  assign out_local.data  = in.data;
  assign out_local.first = in.first;
  assign out_local.last  = in.last;
  assign out_local.valid = !rst && in.valid && w_sel_local;

  assign out_ring.data   = in.data;
  assign out_ring.first  = in.first;
  assign out_ring.last   = in.last;
  assign out_ring.valid  = !rst && in.valid && w_sel_ring;

  assign w_xfer   = in.valid && in.ready;
  assign w_orphan = w_xfer && (r_state == IDLE) && !in.first;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_drop_cnt <= '0;
    end else begin
      if (w_orphan && !(&r_drop_cnt)) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_xfer && in.first && !in.last) begin
            r_state <= w_dest_hit ? WORM_LOCAL : WORM_RING;
          end
        end
        WORM_LOCAL, WORM_RING: begin
          if (w_xfer && in.last) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign drop_cnt = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ring_router_demux.sv
// ============================================================================
//  Module      : tb_ring_router_demux
//  Description : Directed scoreboard bench for ring_router_demux.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ring_router_demux;

  localparam int DEST_WIDTH = 10;
  localparam int CNT_WIDTH  = 8;
  localparam int TGT_LOCAL  = 0;
  localparam int TGT_RING   = 1;
  localparam int TGT_DROP   = 2;

  logic                  clk;
  logic                  rst;
  logic [DEST_WIDTH-1:0] id;
  logic [CNT_WIDTH-1:0]  drop_cnt;

  dii_channel in_ch ();
  dii_channel loc_ch ();
  dii_channel ring_ch ();

  ring_router_demux #(
    .DEST_WIDTH (DEST_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .id        (id),
    .in        (in_ch),
    .out_local (loc_ch),
    .out_ring  (ring_ch),
    .drop_cnt  (drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  logic [17:0] exp_local[$];
  logic [17:0] exp_ring[$];
  logic        rr_pat[$];
  int          exp_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Scoreboard side: every completed output transfer must match the queue head.
  task automatic monitor();
    logic [17:0] e;
    if (loc_ch.valid === 1'b1 && loc_ch.ready === 1'b1) begin
      chk("local_expected", {31'd0, exp_local.size() > 0}, 32'd1);
      if (exp_local.size() > 0) begin
        e = exp_local.pop_front();
        chk("local_flit", {14'd0, loc_ch.first, loc_ch.last, loc_ch.data}, {14'd0, e});
      end
    end
    if (ring_ch.valid === 1'b1 && ring_ch.ready === 1'b1) begin
      chk("ring_expected", {31'd0, exp_ring.size() > 0}, 32'd1);
      if (exp_ring.size() > 0) begin
        e = exp_ring.pop_front();
        chk("ring_flit", {14'd0, ring_ch.first, ring_ch.last, ring_ch.data}, {14'd0, e});
      end
    end
  endtask

  task automatic send_flit(input logic [15:0] d, input logic f, input logic l, input int tgt);
    logic done;
    logic exp_rdy;
    in_ch.data  = d;
    in_ch.first = f;
    in_ch.last  = l;
    in_ch.valid = 1'b1;
    if (tgt == TGT_LOCAL) exp_local.push_back({f, l, d});
    if (tgt == TGT_RING)  exp_ring.push_back({f, l, d});
    done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      if (rr_pat.size() > 0) ring_ch.ready = rr_pat.pop_front();
      #2;
      exp_rdy = (tgt == TGT_LOCAL) ? loc_ch.ready :
                (tgt == TGT_RING)  ? ring_ch.ready : 1'b1;
      chk("in_ready", {31'd0, in_ch.ready}, {31'd0, exp_rdy});
      chk("local_valid", {31'd0, loc_ch.valid}, {31'd0, tgt == TGT_LOCAL});
      chk("ring_valid", {31'd0, ring_ch.valid}, {31'd0, tgt == TGT_RING});
      monitor();
      done = (in_ch.ready === 1'b1);
      @(posedge clk);
      @(negedge clk);
    end
    if (!done) chk("send_timeout", 32'd1, {31'd0, done});
    in_ch.valid = 1'b0;
  endtask

  task automatic idle_cycle();
    in_ch.valid = 1'b0;
    #2;
    chk("idle_local_valid", {31'd0, loc_ch.valid}, 32'd0);
    chk("idle_ring_valid", {31'd0, ring_ch.valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst           = 1'b1;
    id            = 10'h005;
    in_ch.data    = 16'h0000;
    in_ch.first   = 1'b0;
    in_ch.last    = 1'b0;
    in_ch.valid   = 1'b0;
    loc_ch.ready  = 1'b1;
    ring_ch.ready = 1'b1;
    exp_drop      = 0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ch.ready}, 32'd0);
    chk("rst_local_valid", {31'd0, loc_ch.valid}, 32'd0);
    chk("rst_ring_valid", {31'd0, ring_ch.valid}, 32'd0);
    chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    rst = 1'b0;
    idle_cycle();

    // 3-flit local worm, back to back
    send_flit(16'h0005, 1'b1, 1'b0, TGT_LOCAL);
    send_flit(16'hA001, 1'b0, 1'b0, TGT_LOCAL);
    send_flit(16'hA002, 1'b0, 1'b1, TGT_LOCAL);

    // Single-flit ring packet, then local packet on the very next cycle
    send_flit(16'h0123, 1'b1, 1'b1, TGT_RING);
    send_flit(16'h0005, 1'b1, 1'b1, TGT_LOCAL);
    idle_cycle();

    // 4-flit ring worm under toggling back-pressure
    rr_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    send_flit(16'h0200, 1'b1, 1'b0, TGT_RING);
    send_flit(16'hB001, 1'b0, 1'b0, TGT_RING);
    send_flit(16'hB002, 1'b0, 1'b0, TGT_RING);
    send_flit(16'hB003, 1'b0, 1'b1, TGT_RING);
    ring_ch.ready = 1'b1;
    idle_cycle();

    // Mid-worm first=1 with foreign destination stays local; gap inside worm
    send_flit(16'h0005, 1'b1, 1'b0, TGT_LOCAL);
    send_flit(16'h00FF, 1'b1, 1'b0, TGT_LOCAL);
    idle_cycle();
    send_flit(16'hC003, 1'b0, 1'b1, TGT_LOCAL);
    chk("drop_after_worms", {24'd0, drop_cnt}, 32'd0);

    // Orphans in IDLE
    for (int i = 0; i < 3; i++) begin
      send_flit(16'hD000 + 16'(i), 1'b0, 1'b0, TGT_DROP);
      exp_drop++;
    end
    chk("drop_cnt_3", {24'd0, drop_cnt}, exp_drop);

    // Reset mid-worm truncates; tail flits become orphans
    send_flit(16'h0005, 1'b1, 1'b0, TGT_LOCAL);
    send_flit(16'hE002, 1'b0, 1'b0, TGT_LOCAL);
    rst = 1'b1;
    #2;
    chk("midrst_in_ready", {31'd0, in_ch.ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_drop = 0;
    chk("midrst_drop_cnt", {24'd0, drop_cnt}, exp_drop);
    for (int i = 3; i <= 5; i++) begin
      send_flit(16'hE000 + 16'(i), 1'b0, (i == 5), TGT_DROP);
      exp_drop++;
    end
    chk("tail_drop_cnt", {24'd0, drop_cnt}, exp_drop);

    // Saturation: reach 255 orphans, then one more
    while (exp_drop < 255) begin
      send_flit(16'hF000, 1'b0, 1'b0, TGT_DROP);
      exp_drop++;
    end
    chk("drop_cnt_255", {24'd0, drop_cnt}, 32'd255);
    send_flit(16'hF001, 1'b0, 1'b0, TGT_DROP);
    chk("drop_cnt_sat", {24'd0, drop_cnt}, 32'd255);

    // Router still routes after saturation
    send_flit(16'h0005, 1'b1, 1'b1, TGT_LOCAL);
    idle_cycle();

    chk("local_queue_drained", exp_local.size(), 32'd0);
    chk("ring_queue_drained", exp_ring.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ring_router_demux.md
Name: ring_router_demux

Overview:
- Ingress half of a debug ring router; the counterpart of the ring egress merge stage.
- Takes the DII flit stream arriving from the upstream ring segment.
- Steers each packet (worm) either to the local module or onward to the downstream ring, based on the destination field of the first flit.
- Flits of one worm are never split across outputs; non-first flits arriving outside a worm are discarded and counted.

Parameters:
- DEST_WIDTH, 10, width of destination field, taken from data[DEST_WIDTH-1:0] of a first flit
- CNT_WIDTH, 8, width of saturating drop counter

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- id  input  DEST_WIDTH  this router's address; sampled combinationally, must be static outside reset
- in  dii_channel.slave  -  upstream ring flits: data[15:0], first, last, valid in; ready out
- out_local  dii_channel.master  -  flits addressed to id: data, first, last, valid out; ready in
- out_ring  dii_channel.master  -  flits for other addresses: same fields as out_local
- drop_cnt  output  CNT_WIDTH  number of orphan flits discarded, saturating

Behaviour:
- Handshake: a flit transfers on a channel when valid and ready are both 1 on a rising clk edge. No combinational path from in.valid to in.ready.
- Data path is zero latency: the selected output mirrors in.data/first/last combinationally. The inactive output has valid=0 and data/first/last don't-care.
- FSM states: IDLE, WORM_LOCAL, WORM_RING. Reset state is IDLE.
- IDLE:
  - in.valid && in.first && data[DEST_WIDTH-1:0]==id: route to out_local (out_local.valid=1, in.ready=out_local.ready).
  - in.valid && in.first && dest!=id: route to out_ring (in.ready=out_ring.ready).
  - Leave IDLE only on a completed transfer with last=0: go to WORM_LOCAL or WORM_RING respectively.
  - A single-flit packet (first&last) transfers and the FSM stays in IDLE.
  - Stalled first flit (target ready=0): stay in IDLE, hold the routing decision combinationally. The upstream must hold data stable.
  - in.valid && !in.first (orphan): in.ready=1, flit discarded, no output valid. drop_cnt increments by 1 unless it is all-ones, in which case it saturates.
- WORM_LOCAL / WORM_RING:
  - Connect in to the chosen output: out_x.valid=in.valid, in.ready=out_x.ready.
  - Destination is not re-decoded. A flit with first=1 mid-worm is forwarded unchanged as part of the worm.
  - Return to IDLE on a transfer with last=1. Otherwise hold state, including across stalls and valid gaps.
- The other output never asserts valid while a worm is active. Back-pressure on one output stalls the whole ingress, which is intentional head-of-line blocking.
- Reset values: state=IDLE; drop_cnt=0. With in.valid=0: out_local.valid=0, out_ring.valid=0, in.ready=0.
- Reset asserted mid-worm: the FSM returns to IDLE and the worm is truncated. Remaining flits of that worm, which carry first=0, are then dropped as orphans and counted.
- The counter updates only when not in reset. Reset has priority over any transfer in the same cycle.

Test Plan:
- id=0x005; send 3-flit worm with dest 0x005 (first flit data=0x0005), out_local.ready=1 -> 3 flits on out_local in 3 consecutive cycles, out_ring.valid never 1, state IDLE after last.
- id=0x005; single-flit packet first=last=1, dest 0x123 -> one transfer on out_ring, FSM stays IDLE; immediately following local packet routes to out_local on the next cycle.
- Ring worm of 4 flits with out_ring.ready toggling 1,0,0,1,1,0,1 -> in.ready tracks out_ring.ready each cycle, all 4 flits delivered in order, no flit reaches out_local.
- In IDLE, present 3 flits with first=0 -> in.ready=1 each cycle, no output valid, drop_cnt=3; preload 255 orphans -> drop_cnt stays 255 after the 256th.
- Assert rst for one cycle after flit 2 of a 5-flit local worm -> state IDLE, drop_cnt=0; flits 3-5 (first=0) are dropped and drop_cnt=3.
- Local worm with a flit carrying first=1 and dest 0x0ff in position 2 -> still delivered to out_local; routing unchanged until last.
